// File: rtl/cpu_pkg.sv
// Shared encodings for the multicycle CPU control path: sequencer states and
// the instruction classes reported by the decoder.
package cpu_pkg;

  localparam logic [2:0] S_BOOT   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_HALT   = 3'd6;

  localparam logic [1:0] TYPE_ALU    = 2'b00;
  localparam logic [1:0] TYPE_LOAD   = 2'b01;
  localparam logic [1:0] TYPE_STORE  = 2'b10;
  localparam logic [1:0] TYPE_BRANCH = 2'b11;

endpackage

// File: rtl/pc_unit.sv
// Program counter register: a taken-branch load has priority over the
// post-fetch increment, which wraps modulo 2^ADDR_W.
module pc_unit #(
  parameter int              ADDR_W   = 10,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inc,
  input  logic              load,
  input  logic [ADDR_W-1:0] target,
  output logic [ADDR_W-1:0] pc
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      pc <= RESET_PC;
    else if (load)
      pc <= target;
    else if (inc)
      pc <= pc + 1'b1;
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Multicycle fetch/decode/execute/memory/writeback sequencer with a
// ready-handshaked shared memory port, taken branches and halt at boundaries.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = 10,
  parameter int                INSTR_W  = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic               mem_rd,
  output logic               mem_wr,
  input  logic               mem_ready,
  input  logic [INSTR_W-1:0] mem_rdata,
  input  logic [ADDR_W-1:0]  ls_addr,
  input  logic [1:0]         instr_type,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  input  logic               halt_req,
  output logic [INSTR_W-1:0] instr,
  output logic [INSTR_W-1:0] mem_data,
  output logic [ADDR_W-1:0]  pc,
  output logic               reg_wen,
  output logic               flags_en,
  output logic               wb_sel,
  output logic               halted,
  output logic [2:0]         state
);

  logic [2:0] state_q;
  logic [2:0] state_next;
  logic [2:0] boundary;
  logic [1:0] itype_q;
  logic       fetch_done;
  logic       pc_load;

  assign state      = state_q;
  assign halted     = (state_q == S_HALT);
  assign boundary   = halt_req ? S_HALT : S_FETCH;
  assign fetch_done = (state_q == S_FETCH) && mem_ready;
  assign pc_load    = (state_q == S_EXEC) && (itype_q == TYPE_BRANCH) && branch_taken;
  assign mem_addr   = (state_q == S_MEM) ? ls_addr : pc;

  pc_unit #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk    (clk),
    .reset  (reset),
    .inc    (fetch_done),
    .load   (pc_load),
    .target (branch_target),
    .pc     (pc)
  );

  always_comb begin
    state_next = state_q;
    case (state_q)
      S_BOOT:   state_next = S_FETCH;
      S_FETCH:  if (mem_ready) state_next = S_DECODE;
      S_DECODE: state_next = S_EXEC;
      S_EXEC:   state_next = (itype_q == TYPE_LOAD || itype_q == TYPE_STORE) ? S_MEM : boundary;
      S_MEM:    if (mem_ready) state_next = (itype_q == TYPE_LOAD) ? S_WB : boundary;
      S_WB:     state_next = boundary;
      S_HALT:   if (!halt_req) state_next = S_FETCH;
      default:  state_next = S_BOOT;
    endcase
  end

  // Strobes depend only on state and the type latched in DECODE, so a
  // decoder output that changes mid-instruction cannot disturb them.
  always_comb begin
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    reg_wen  = 1'b0;
    flags_en = 1'b0;
    wb_sel   = 1'b0;
    case (state_q)
      S_FETCH: mem_rd = 1'b1;
      S_EXEC: begin
        reg_wen  = (itype_q == TYPE_ALU);
        flags_en = (itype_q == TYPE_ALU);
      end
      S_MEM: begin
        mem_rd = (itype_q == TYPE_LOAD);
        mem_wr = (itype_q == TYPE_STORE);
      end
      S_WB: begin
        reg_wen = 1'b1;
        wb_sel  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_BOOT;
      itype_q  <= TYPE_ALU;
      instr    <= '0;
      mem_data <= '0;
    end else begin
      state_q <= state_next;
      if (state_q == S_DECODE)
        itype_q <= instr_type;
      if (fetch_done)
        instr <= mem_rdata;
      if (state_q == S_MEM && itype_q == TYPE_LOAD && mem_ready)
        mem_data <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: directed timing cases, then a random program run
// checked by a scoreboard fed from an instruction-level program model.
module tb_cpu_sequencer;

  localparam int AW = 10;
  localparam int IW = 16;

  localparam logic [1:0] K_RD  = 2'd0;
  localparam logic [1:0] K_WR  = 2'd1;
  localparam logic [1:0] K_ALU = 2'd2;
  localparam logic [1:0] K_LDW = 2'd3;

  typedef struct packed {
    logic [1:0]    kind;
    logic [AW-1:0] addr;
    logic [IW-1:0] data;
  } ev_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [AW-1:0] mem_addr;
  logic          mem_rd, mem_wr;
  logic          mem_ready = 1'b0;
  logic [IW-1:0] mem_rdata;
  logic [AW-1:0] ls_addr;
  logic [1:0]    instr_type;
  logic          branch_taken;
  logic [AW-1:0] branch_target;
  logic          halt_req = 1'b0;
  logic [IW-1:0] instr, mem_data;
  logic [AW-1:0] pc;
  logic          reg_wen, flags_en, wb_sel, halted;
  logic [2:0]    state;

  logic [IW-1:0] mem [0:(1<<AW)-1];
  ev_t           q[$];
  int            checks = 0;
  int            errors = 0;
  int            fixed_wait = 0;
  int            wcnt = 0;
  int            wr_done = 0;
  bit            force_low = 1'b0;
  bit            sb_en = 1'b0;

  cpu_sequencer #(
    .ADDR_W   (AW),
    .INSTR_W  (IW),
    .RESET_PC (10'h000)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .mem_addr      (mem_addr),
    .mem_rd        (mem_rd),
    .mem_wr        (mem_wr),
    .mem_ready     (mem_ready),
    .mem_rdata     (mem_rdata),
    .ls_addr       (ls_addr),
    .instr_type    (instr_type),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .halt_req      (halt_req),
    .instr         (instr),
    .mem_data      (mem_data),
    .pc            (pc),
    .reg_wen       (reg_wen),
    .flags_en      (flags_en),
    .wb_sel        (wb_sel),
    .halted        (halted),
    .state         (state)
  );

  always #5 clk = ~clk;

  // Memory and a toy decoder: [15:14] type, [13] taken, [9:0] address/target.
  assign mem_rdata     = mem[mem_addr];
  assign instr_type    = instr[15:14];
  assign branch_taken  = instr[13];
  assign branch_target = instr[9:0];
  assign ls_addr       = instr[9:0];

  function automatic int pick_wait();
    return (fixed_wait < 0) ? int'($urandom_range(0, 3)) : fixed_wait;
  endfunction

  always begin
    @(negedge clk);
    if (reset || force_low || !(mem_rd || mem_wr)) begin
      mem_ready = 1'b0;
      if (reset) wcnt = pick_wait();
    end else if (wcnt == 0) begin
      mem_ready = 1'b1;
      if (mem_wr) wr_done++;
      wcnt = pick_wait();
    end else begin
      mem_ready = 1'b0;
      wcnt--;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Holds reset for two cycles and releases it; the caller is then in cycle 1.
  task automatic start_run();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  function automatic ev_t mk(input logic [1:0] k, input int unsigned a, input logic [IW-1:0] d);
    ev_t e;
    e.kind = k;
    e.addr = AW'(a);
    e.data = d;
    return e;
  endfunction

  // Instruction-level program walk producing the expected event sequence.
  function automatic void build_expect(input int n);
    int unsigned p = 0;
    for (int i = 0; i < n; i++) begin
      logic [IW-1:0] w;
      int unsigned   a;
      int unsigned   np;
      w  = mem[p];
      a  = int'(w[9:0]);
      np = (p + 1) % (1 << AW);
      q.push_back(mk(K_RD, p, '0));
      case (w[15:14])
        2'd0: q.push_back(mk(K_ALU, 0, '0));
        2'd1: begin
          q.push_back(mk(K_RD, a, '0));
          q.push_back(mk(K_LDW, 0, mem[a]));
        end
        2'd2: q.push_back(mk(K_WR, a, '0));
        default: if (w[13]) np = a;
      endcase
      p = np;
    end
  endfunction

  task automatic take(input logic [1:0] kind);
    ev_t e;
    if (q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL sb_extra: got kind %0d expected no event", kind);
    end else begin
      e = q.pop_front();
      chk("sb_kind", 32'(kind), 32'(e.kind));
      if (e.kind == K_RD || e.kind == K_WR) chk("sb_addr", 32'(mem_addr), 32'(e.addr));
      if (e.kind == K_ALU) chk("sb_flags_en", 32'(flags_en), 32'd1);
      if (e.kind == K_LDW) chk("sb_load_data", 32'(mem_data), 32'(e.data));
    end
  endtask

  always begin
    @(negedge clk);
    #1;
    if (sb_en && !reset) begin
      if (mem_rd || mem_wr) chk("rd_wr_exclusive", 32'(mem_rd && mem_wr), 32'd0);
      if ((mem_rd || mem_wr) && mem_ready) take(mem_wr ? K_WR : K_RD);
      if (reg_wen) take(wb_sel ? K_LDW : K_ALU);
      if (halted) chk("halt_quiet", {29'd0, mem_rd, mem_wr, reg_wen}, 32'd0);
    end
  end

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;

    // Reset values, then ALU timing with zero wait states
    fixed_wait = 0;
    mem[0] = 16'h0123;
    step();
    reset = 1'b1;
    step();
    step();
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_instr", 32'(instr), 32'd0);
    chk("rst_mem_data", 32'(mem_data), 32'd0);
    chk("rst_strobes", {27'd0, mem_rd, mem_wr, reg_wen, flags_en, wb_sel}, 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    reset = 1'b0;
    chk("alu_c1_idle", 32'(mem_rd), 32'd0);
    step();
    chk("alu_c2_rd", {31'd0, mem_rd}, 32'd1);
    chk("alu_c2_addr", 32'(mem_addr), 32'd0);
    step();
    chk("alu_c3_state", 32'(state), 32'd2);
    step();
    chk("alu_c4_wen", {29'd0, reg_wen, flags_en, wb_sel}, 32'b110);
    step();
    chk("alu_c5_fetch", {21'd0, mem_rd, mem_addr}, {21'd0, 1'b1, 10'h001});

    // Fetch with three wait states
    fixed_wait = 3;
    mem[0] = 16'h1234;
    start_run();
    for (int c = 2; c <= 5; c++) begin
      step();
      chk("fw_rd_stable", {21'd0, mem_rd, mem_addr}, {21'd0, 1'b1, 10'h000});
      if (c < 5) begin
        chk("fw_instr_hold", 32'(instr), 32'd0);
        chk("fw_pc_hold", 32'(pc), 32'd0);
      end
    end
    step();
    chk("fw_instr", 32'(instr), 32'h1234);
    chk("fw_pc", 32'(pc), 32'd1);

    // Load from 0x155 returning 0xBEEF
    fixed_wait = 0;
    mem[0] = 16'h4155;
    mem[10'h155] = 16'hBEEF;
    start_run();
    step();
    step();
    step();
    chk("ld_exec_quiet", {29'd0, mem_rd, reg_wen, flags_en}, 32'd0);
    step();
    chk("ld_mem_rd", {21'd0, mem_rd, mem_addr}, {21'd0, 1'b1, 10'h155});
    step();
    chk("ld_mem_data", 32'(mem_data), 32'hBEEF);
    chk("ld_wb", {29'd0, reg_wen, wb_sel, flags_en}, 32'b110);
    step();
    chk("ld_next_fetch", {21'd0, mem_rd, mem_addr}, {21'd0, 1'b1, 10'h001});

    // Branch at 0x3FF: taken to 0x010, then not taken (wraps to 0x000)
    for (int t = 0; t < 2; t++) begin
      mem[0] = 16'hE3FF;
      mem[10'h3FF] = (t == 0) ? 16'hE010 : 16'hC010;
      start_run();
      step();
      step();
      step();
      step();
      chk("br_fetch_3ff", {21'd0, mem_rd, mem_addr}, {21'd0, 1'b1, 10'h3FF});
      step();
      chk("br_pc_wrap", 32'(pc), 32'd0);
      step();
      step();
      chk("br_next_fetch", {21'd0, mem_rd, mem_addr}, (t == 0) ? 32'h410 : 32'h400);
    end

    // Halt requested while a store waits on memory
    fixed_wait = 3;
    mem[0] = 16'h82AA;
    start_run();
    wr_done = 0;
    for (int c = 2; c <= 8; c++) step();
    chk("st_mem_wr", {20'd0, mem_rd, mem_wr, mem_addr}, {20'd0, 2'b01, 10'h2AA});
    step();
    halt_req = 1'b1;
    step();
    step();
    step();
    chk("st_halted", {29'd0, halted, mem_rd, mem_wr}, 32'b100);
    chk("st_halt_state", 32'(state), 32'd6);
    chk("st_write_done", 32'(wr_done), 32'd1);
    step();
    chk("st_halt_hold", {29'd0, halted, mem_rd, mem_wr}, 32'b100);
    halt_req = 1'b0;
    step();
    chk("st_resume", {20'd0, halted, mem_rd, mem_addr}, {20'd0, 2'b01, 10'h001});

    // Reset landing in the middle of a load memory access
    fixed_wait = 0;
    mem[0] = 16'h4155;
    start_run();
    step();
    step();
    step();
    force_low = 1'b1;
    step();
    chk("rl_mem_rd", {21'd0, mem_rd, mem_addr}, {21'd0, 1'b1, 10'h155});
    reset = 1'b1;
    #1;
    chk("rl_rd_drop", {30'd0, mem_rd, reg_wen}, 32'd0);
    chk("rl_pc", 32'(pc), 32'd0);
    chk("rl_state", 32'(state), 32'd0);
    force_low = 1'b0;

    // Random program with random wait states and random halt requests
    fixed_wait = -1;
    step();
    for (int i = 0; i < (1 << AW); i++) mem[i] = IW'($urandom);
    q.delete();
    build_expect(300);
    sb_en = 1'b1;
    start_run();
    for (int c = 0; c < 40000 && q.size() != 0; c++) begin
      step();
      if ($urandom_range(0, 19) == 0) halt_req = ~halt_req;
    end
    sb_en = 1'b0;
    halt_req = 1'b0;
    chk("sb_drain", 32'(q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
